// File: rtl/insn_encoder_pkg.sv
// Shared LEGv8 encoding definitions: op enum, opcode constants (the same
// values the control decoder matches), field positions, loader FSM states
// and immediate range helpers.
package insn_encoder_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_ORR  = 4'd3,
        OP_ADDI = 4'd4,
        OP_SUBI = 4'd5,
        OP_LDUR = 4'd6,
        OP_STUR = 4'd7,
        OP_CBZ  = 4'd8,
        OP_B    = 4'd9,
        OP_MOVZ = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
    localparam logic [8:0]  OPC_MOVZ = 9'b110100101;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [5:0]  OPC_B    = 6'b000101;

    // Field LSB positions within the 32-bit machine word.
    localparam int RD_LSB    = 0;
    localparam int RN_LSB    = 5;
    localparam int SHAMT_LSB = 10;
    localparam int RM_LSB    = 16;
    localparam int HW_LSB    = 21;

    // True when imm[25:nbits-1] are all copies of the sign bit.
    function automatic logic fits_signed(input logic [25:0] imm, input int nbits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 26; i++) begin
            if (i >= nbits - 1 && imm[i] != imm[nbits-1]) ok = 1'b0;
        end
        return ok;
    endfunction

    // True when imm[25:nbits] are all zero.
    function automatic logic fits_unsigned(input logic [25:0] imm, input int nbits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 26; i++) begin
            if (i >= nbits && imm[i]) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/insn_encoder_pack.sv
// insn_pack: combinational LEGv8 packer.
// Ports: op/rd/rn/rm/imm/hw in -> word (machine code), legal (op known and
// immediate in range). word is zero when legal is low.
module insn_pack
    import insn_encoder_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [25:0] imm,
    input  logic [1:0]  hw,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (op)
            OP_ADD:  word = {OPC_ADD, rm, 6'b0, rn, rd};
            OP_SUB:  word = {OPC_SUB, rm, 6'b0, rn, rd};
            OP_AND:  word = {OPC_AND, rm, 6'b0, rn, rd};
            OP_ORR:  word = {OPC_ORR, rm, 6'b0, rn, rd};
            OP_ADDI: begin
                legal = fits_unsigned(imm, 12);
                word  = {OPC_ADDI, imm[11:0], rn, rd};
            end
            OP_SUBI: begin
                legal = fits_unsigned(imm, 12);
                word  = {OPC_SUBI, imm[11:0], rn, rd};
            end
            OP_LDUR: begin
                legal = fits_signed(imm, 9);
                word  = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
            end
            OP_STUR: begin
                legal = fits_signed(imm, 9);
                word  = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
            end
            OP_CBZ: begin
                legal = fits_signed(imm, 19);
                word  = {OPC_CBZ, imm[18:0], rd};
            end
            OP_B:    word = {OPC_B, imm};
            OP_MOVZ: begin
                legal = fits_unsigned(imm, 16);
                word  = {OPC_MOVZ, hw, imm[15:0], rd};
            end
            default: legal = 1'b0;
        endcase
        if (!legal) word = '0;
    end

endmodule

// File: rtl/insn_encoder.sv
// insn_encoder: streaming LEGv8 encoder and instruction-memory loader.
// Ports: CLK/resetl; start opens a session; in_* is a valid/ready stream of
// symbolic instructions; imem_* is a registered write port at
// BASE_ADDR + 4*index; busy/done/err/count report session status.
//
// state | meaning
// IDLE  | after reset, waiting for start
// LOAD  | accepting beats, one write per accepted legal beat
// DONE  | in_last written or DEPTH words written (overflow sets err)
// ERR   | illegal op or out-of-range immediate; nothing written
module insn_encoder
    import insn_encoder_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic                   CLK,
    input  logic                   resetl,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_op,
    input  logic [4:0]             in_rd,
    input  logic [4:0]             in_rn,
    input  logic [4:0]             in_rm,
    input  logic [25:0]            in_imm,
    input  logic [1:0]             in_hw,
    input  logic                   in_last,
    output logic                   imem_we,
    output logic [63:0]            imem_addr,
    output logic [31:0]            imem_wdata,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e         state_q, state_d;
    logic           we_q, we_d;
    logic [63:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [CW-1:0]  count_q, count_d;

    logic [31:0]    word;
    logic           legal;
    logic           accept;
    logic           last_slot;

    insn_pack u_pack (
        .op    (in_op),
        .rd    (in_rd),
        .rn    (in_rn),
        .rm    (in_rm),
        .imm   (in_imm),
        .hw    (in_hw),
        .word  (word),
        .legal (legal)
    );

    assign accept    = in_valid && (state_q == ST_LOAD);
    // count_q counts completed writes, so this beat would be the DEPTH-th.
    assign last_slot = (count_q == CW'(DEPTH - 1));

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    if (!legal)                    state_d = ST_ERR;
                    else if (in_last || last_slot) state_d = ST_DONE;
                end
            end
            default: if (start) state_d = ST_LOAD;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ST_LOAD);
        busy     = (state_q == ST_LOAD);
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        count_d  = count_q;
        done_d   = done_q;
        err_d    = err_q;
        if (state_q != ST_LOAD && start) begin
            count_d = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else if (accept) begin
            if (!legal) begin
                err_d = 1'b1;
            end else begin
                we_d    = 1'b1;
                addr_d  = BASE_ADDR + 64'({count_q, 2'b00});
                wdata_d = word;
                count_d = count_q + CW'(1);
                if (in_last) begin
                    done_d = 1'b1;
                end else if (last_slot) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign done       = done_q;
    assign err        = err_q;
    assign count      = count_q;

endmodule

// File: tb/tb_insn_encoder.sv
module tb_insn_encoder;

    localparam int          DEPTH = 4;
    localparam logic [63:0] BASE  = 64'h0000_0000_0000_1000;

    logic        CLK = 1'b0;
    logic        resetl;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rd, in_rn, in_rm;
    logic [25:0] in_imm;
    logic [1:0]  in_hw;
    logic        in_last;
    logic        imem_we;
    logic [63:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        busy, done, err;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_mis = 0;

    insn_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .CLK        (CLK),
        .resetl     (resetl),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rn      (in_rn),
        .in_rm      (in_rm),
        .in_imm     (in_imm),
        .in_hw      (in_hw),
        .in_last    (in_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .count      (count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic beat(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                        input logic [4:0] rm, input logic [25:0] imm, input logic [1:0] hw,
                        input logic last);
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_rn    = rn;
        in_rm    = rm;
        in_imm   = imm;
        in_hw    = hw;
        in_last  = last;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".we"},    64'(imem_we),    64'd0);
        chk({tag, ".addr"},  imem_addr,       64'd0);
        chk({tag, ".wdata"}, 64'(imem_wdata), 64'd0);
        chk({tag, ".busy"},  64'(busy),       64'd0);
        chk({tag, ".ready"}, 64'(in_ready),   64'd0);
        chk({tag, ".done"},  64'(done),       64'd0);
        chk({tag, ".err"},   64'(err),        64'd0);
        chk({tag, ".count"}, 64'(count),      64'd0);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        resetl = 1'b0;
        start  = 1'b0;
        in_op  = '0; in_rd = '0; in_rn = '0; in_rm = '0;
        in_imm = '0; in_hw = '0;
        idle_in();
        step();
        chk_all_zero("reset");
        resetl = 1'b1;
        step();
        chk("idle_ready", 64'(in_ready), 64'd0);

        // ADD rd=1 rn=2 rm=3
        do_start();
        chk("load_busy", 64'(busy), 64'd1);
        beat(4'd0, 5'd1, 5'd2, 5'd3, 26'd0, 2'd0, 1'b0);
        chk("add_pre_we", 64'(imem_we), 64'd0);
        step();
        idle_in();
        chk("add_we",    64'(imem_we),    64'd1);
        chk("add_addr",  imem_addr,       BASE);
        chk("add_word",  64'(imem_wdata), 64'h8B030041);
        chk("add_count", 64'(count),      64'd1);
        chk("add_done",  64'(done),       64'd0);

        // start ignored while loading; then reset between accept and write
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_in_load_count", 64'(count), 64'd1);
        beat(4'd1, 5'd4, 5'd5, 5'd6, 26'd0, 2'd0, 1'b0);
        @(posedge CLK);
        #1;
        chk("pend_we", 64'(imem_we), 64'd1);
        resetl = 1'b0;
        #1;
        chk_all_zero("midreset");
        idle_in();
        step();
        resetl = 1'b1;
        step();
        chk("postreset_ready", 64'(in_ready), 64'd0);
        chk("postreset_we",    64'(imem_we),  64'd0);

        // LDUR rd=9 rn=10 imm=-8, then MOVZ rd=5 imm=0xBEEF hw=2 last
        do_start();
        beat(4'd6, 5'd9, 5'd10, 5'd0, 26'h3FFFFF8, 2'd0, 1'b0);
        step();
        beat(4'd10, 5'd5, 5'd0, 5'd0, 26'h000BEEF, 2'd2, 1'b1);
        chk("ldur_we",   64'(imem_we),    64'd1);
        chk("ldur_addr", imem_addr,       BASE);
        chk("ldur_word", 64'(imem_wdata), 64'hF85F8149);
        chk("ldur_done", 64'(done),       64'd0);
        step();
        idle_in();
        chk("movz_we",    64'(imem_we),    64'd1);
        chk("movz_addr",  imem_addr,       BASE + 64'd4);
        chk("movz_word",  64'(imem_wdata), 64'hD2D7DDE5);
        chk("movz_done",  64'(done),       64'd1);
        chk("movz_count", 64'(count),      64'd2);
        chk("movz_ready", 64'(in_ready),   64'd0);
        step();
        chk("done_we",   64'(imem_we), 64'd0);
        chk("done_hold", 64'(done),    64'd1);

        // CBZ rd=7 imm=-2, B imm=3 back-to-back
        do_start();
        chk("restart_done", 64'(done),  64'd0);
        chk("restart_count", 64'(count), 64'd0);
        beat(4'd8, 5'd7, 5'd0, 5'd0, 26'h3FFFFFE, 2'd0, 1'b0);
        step();
        beat(4'd9, 5'd0, 5'd0, 5'd0, 26'd3, 2'd0, 1'b1);
        chk("cbz_we",   64'(imem_we),    64'd1);
        chk("cbz_word", 64'(imem_wdata), 64'hB4FFFFC7);
        step();
        idle_in();
        chk("b_we",   64'(imem_we),    64'd1);
        chk("b_addr", imem_addr,       BASE + 64'd4);
        chk("b_word", 64'(imem_wdata), 64'h14000003);
        chk("b_done", 64'(done),       64'd1);

        // ADDI imm=0x1000 out of range
        do_start();
        beat(4'd4, 5'd1, 5'd1, 5'd0, 26'h0001000, 2'd0, 1'b0);
        step();
        chk("addi_err",   64'(err),      64'd1);
        chk("addi_we",    64'(imem_we),  64'd0);
        chk("addi_ready", 64'(in_ready), 64'd0);
        chk("addi_count", 64'(count),    64'd0);
        step();
        idle_in();
        chk("err_stuck_ready", 64'(in_ready), 64'd0);
        chk("err_stuck_we",    64'(imem_we),  64'd0);
        do_start();
        chk("addi_clr_err", 64'(err),  64'd0);
        chk("addi_busy",    64'(busy), 64'd1);

        // illegal op 12
        beat(4'd12, 5'd1, 5'd1, 5'd1, 26'd0, 2'd0, 1'b0);
        step();
        idle_in();
        chk("op12_err", 64'(err),      64'd1);
        chk("op12_we",  64'(imem_we),  64'd0);
        chk("op12_rdy", 64'(in_ready), 64'd0);

        // start together with a valid beat: no acceptance that cycle
        start = 1'b1;
        beat(4'd0, 5'd1, 5'd2, 5'd3, 26'd0, 2'd0, 1'b0);
        step();
        start = 1'b0;
        idle_in();
        chk("startvalid_we",    64'(imem_we), 64'd0);
        chk("startvalid_count", 64'(count),   64'd0);
        chk("startvalid_err",   64'(err),     64'd0);

        // overflow: DEPTH=4, five beats, no last
        for (int i = 0; i < 5; i++) begin
            beat(4'd0, 5'(i + 1), 5'd2, 5'd3, 26'd0, 2'd0, 1'b0);
            step();
            if (i < 4) begin
                chk($sformatf("ovf_we%0d", i),   64'(imem_we),    64'd1);
                chk($sformatf("ovf_addr%0d", i), imem_addr,       BASE + 64'(4 * i));
                chk($sformatf("ovf_word%0d", i), 64'(imem_wdata), 64'h8B030040 + 64'(i + 1));
            end else begin
                chk("ovf_5th_we", 64'(imem_we),  64'd0);
                chk("ovf_ready",  64'(in_ready), 64'd0);
            end
        end
        idle_in();
        chk("ovf_count", 64'(count), 64'd4);
        chk("ovf_done",  64'(done),  64'd1);
        chk("ovf_err",   64'(err),   64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/insn_encoder.md
# insn_encoder

Streaming LEGv8 instruction encoder and instruction-memory loader: the encoding counterpart of the single-cycle control decoder. It accepts one symbolic instruction per handshake (operation code, register numbers, immediate) and packs it into a 32-bit LEGv8 machine word. It writes the word into consecutive instruction-memory locations starting at a base byte address. It sits between the testbench/boot path and the instruction memory, and fills the program before the datapath is released from reset.

## Interface
- DEPTH, 64, number of 32-bit words the loader may write per session
- BASE_ADDR, 64'h0, byte address of the first written word
- CLK  input  1  rising-edge clock
- resetl  input  1  asynchronous, active-low reset
- start  input  1  begin a load session; clears count, done and err
- in_valid  input  1  symbolic instruction present
- in_ready  output  1  encoder accepts a beat this cycle
- in_op  input  4  operation (package enum)
- in_rd / in_rn / in_rm  input  5 each  Rd/Rt, Rn, Rm
- in_imm  input  26  immediate, two's complement or unsigned per op
- in_hw  input  2  MOVZ shift (LSL 16*hw)
- in_last  input  1  final instruction of the program
- imem_we  output  1  write strobe
- imem_addr  output  64  byte address, BASE_ADDR + 4*index
- imem_wdata  output  32  encoded word
- busy  output  1  state == LOAD
- done  output  1  session ended normally or by overflow
- err  output  1  sticky error flag
- count  output  $clog2(DEPTH)+1  words written this session

## Operation
- Op enum: ADD=0, SUB=1, AND=2, ORR=3, ADDI=4, SUBI=5, LDUR=6, STUR=7, CBZ=8, B=9, MOVZ=10; 11–15 are illegal.
- R-type (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000): [31:21]=opc, [20:16]=Rm, [15:10]=0, [9:5]=Rn, [4:0]=Rd.
- I-type (ADDI 1001000100, SUBI 1101000100): [31:22]=opc, [21:10]=imm[11:0] unsigned, Rn, Rd.
- D-type (LDUR 11111000010, STUR 11111000000): [31:21]=opc, [20:12]=imm[8:0] signed, [11:10]=00, Rn, Rt=in_rd.
- CBZ 10110100: [31:24], [23:5]=imm[18:0] signed, [4:0]=Rt=in_rd.
- B 000101: [31:26], [25:0]=imm.
- MOVZ 110100101: [31:23], [22:21]=hw, [20:5]=imm[15:0] unsigned, Rd.
- Range checks: ADDI/SUBI imm[25:12]==0; MOVZ imm[25:16]==0; LDUR/STUR imm[25:8] all equal; CBZ imm[25:18] all equal. A failed check or an illegal op sets err, writes nothing, and sends the FSM to ERR.
- FSM states: IDLE, LOAD, DONE, ERR.
  - IDLE, DONE or ERR, on start → LOAD: count=0, done=0, err=0.
  - LOAD, on accepting a beat with in_last → DONE.
  - LOAD, on accepting the DEPTH-th beat without in_last → DONE with err=1 (overflow). That word is still written.
  - start is ignored while in LOAD.
- in_ready = (state==LOAD). The memory never stalls, so there is no backpressure beyond the state.
- Reset values: state=IDLE, every output 0, count 0.

## Timing
- Latency is 1 cycle. A beat accepted at edge N yields imem_we=1 with its addr/wdata during cycle N+1. Back-to-back beats give one write per cycle.
- imem_we, imem_addr, imem_wdata, done and err are registered.
- done rises in the same cycle as the final imem_we.
- err for a bad beat rises one cycle after acceptance; imem_we stays 0 in that cycle.
- count increments with each imem_we.
- start and in_valid in the same IDLE cycle: no beat is accepted, because in_ready is still 0.
- resetl asserted mid-session: outputs clear immediately (async). Any pending write is dropped. The session restarts only on a new start.

## Structure
- The shared package holds the op enum, the 11/10/9/8/6-bit opcode constants (the same values the control decoder matches), and the field-position constants. The control decoder and this encoder both import it.
- One natural sub-module: insn_pack, combinational. It maps {op, rd, rn, rm, imm, hw} to {word, legal}. The top level holds the FSM, the counter and the output register.

## Test plan
- start, then ADD rd=1 rn=2 rm=3 → imem_wdata=0x8B030041 at addr BASE_ADDR, one cycle after accept.
- LDUR rd=9 rn=10 imm=-8, then MOVZ rd=5 imm=0xBEEF hw=2 (last) → 0xF85F8149 at +0 and 0xD2D7DDE5 at +4; done=1 in the second write cycle; count=2.
- CBZ rd=7 imm=-2, then B imm=3 back-to-back → 0xB4FFFFC7 and 0x14000003 on consecutive cycles.
- ADDI imm=0x1000, and separately op=12 → err=1, no imem_we, in_ready=0 until start. A following start clears err.
- DEPTH=4 with 5 beats and no in_last → exactly 4 writes, done=1, err=1, 5th beat not accepted.
- Deassert resetl between accept and write → imem_we stays 0, all outputs 0, state IDLE.
